rr_arb_mux: RTL and testbench

// - Parametrised N-to-1 datapath multiplexer with built-in arbitration and one registered output stage.
// - Per-channel valid/ready inputs; a single valid/ready output.
// - Replaces the hardwired 2:1 select-line mux wherever several producers share one consumer,
//   e.g. I-fetch and D-access requests sharing one memory port, or writeback source merging.

---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_grant.sv | 36 +++
 rtl/rr_arb_mux.sv | 93 +++++++++
 tb/tb_rr_arb_mux.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrated N-to-1 multiplexer.
package mux_pkg;

    localparam int unsigned DEF_DATA_W = 32;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // Select width for n channels; a single channel still gets a 1-bit index.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational one-hot picker: round-robin from ptr, or fixed lowest-index priority.
module rr_grant
    import mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  win_idx
);

    localparam int unsigned DBL_W = 2 * NUM_CH;

    logic [DBL_W-1:0] req_dbl;
    logic             found;

    assign req_dbl = {req, req};

    // Bits below ptr in the lower copy are skipped; the upper copy supplies the wrap-around.
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < DBL_W; k++) begin
            if (!found && req_dbl[k] && ((mode == ARB_FIXED) || (k >= 32'(ptr)))) begin
                found   = 1'b1;
                win_idx = SEL_W'(k % NUM_CH);
                gnt     = NUM_CH'(1) << (k % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 valid/ready multiplexer with round-robin or fixed-priority arbitration and a registered output.
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned SEL_W      = sel_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch
);

    localparam logic MODE = (FIXED_PRIO != 0) ? ARB_FIXED : ARB_RR;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  win_idx;
    logic [DATA_W-1:0] mux_data;
    logic              load_en;
    logic              xfer;

    rr_grant #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_grant (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .mode    (MODE),
        .gnt     (gnt),
        .win_idx (win_idx)
    );

    assign load_en  = !out_valid_q || out_ready;
    // Reset gating keeps producers stalled even though the grant logic is still live.
    assign in_ready = (rst_n && load_en) ? gnt : '0;
    assign xfer     = |(in_valid & in_ready);

    // AND-OR payload select driven by the one-hot grant.
    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mux_data = mux_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = mux_data;
                out_ch_d   = win_idx;
                if (MODE == ARB_RR) begin
                    rr_ptr_d = (32'(win_idx) == (NUM_CH - 1)) ? '0 : (win_idx + SEL_W'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a round-robin and a fixed-priority instance share stimulus, checked against a cycle model.
module tb_rr_arb_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic            out_ready;
    logic [DW-1:0]   dat [N];

    logic [N-1:0]    rr_in_ready, fx_in_ready;
    logic            rr_out_valid, fx_out_valid;
    logic [DW-1:0]   rr_out_data, fx_out_data;
    logic [1:0]      rr_out_ch, fx_out_ch;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: 0 = round-robin, 1 = fixed priority.
    int          m_ptr [2];
    logic        m_v   [2];
    logic [31:0] m_d   [2];
    int          m_ch  [2];

    for (genvar g = 0; g < N; g++) begin : g_data
        assign in_data[g*DW +: DW] = dat[g];
    end

    rr_arb_mux #(.DATA_W(DW), .NUM_CH(N), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rr_in_ready),
        .in_data(in_data), .out_valid(rr_out_valid), .out_ready(out_ready),
        .out_data(rr_out_data), .out_ch(rr_out_ch)
    );

    rr_arb_mux #(.DATA_W(DW), .NUM_CH(N), .FIXED_PRIO(1)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(fx_in_ready),
        .in_data(in_data), .out_valid(fx_out_valid), .out_ready(out_ready),
        .out_data(fx_out_data), .out_ch(fx_out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int pick(input int d, input logic [N-1:0] v);
        for (int off = 0; off < int'(N); off++) begin
            int c;
            c = (d == 0) ? (m_ptr[0] + off) % int'(N) : off;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            m_v[d]   = 1'b0;
            m_d[d]   = '0;
            m_ch[d]  = 0;
        end
    endtask

    // One clock: drive after the falling edge, compare, then advance the model over the next rising edge.
    task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic rnd);
        @(negedge clk);
        in_valid  = v;
        out_ready = rdy;
        if (rnd) begin
            for (int c = 0; c < int'(N); c++) dat[c] = {4'(c), 28'($urandom)};
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            int       w;
            logic     load;
            logic [N-1:0] er;
            w    = pick(d, v);
            load = !m_v[d] || rdy;
            er   = (load && w >= 0) ? (N'(1) << w) : '0;
            chk(d == 0 ? "rr_in_ready" : "fx_in_ready", 64'(d == 0 ? rr_in_ready : fx_in_ready), 64'(er));
            chk(d == 0 ? "rr_out_valid" : "fx_out_valid", 64'(d == 0 ? rr_out_valid : fx_out_valid), 64'(m_v[d]));
            chk(d == 0 ? "rr_out_data" : "fx_out_data", 64'(d == 0 ? rr_out_data : fx_out_data), 64'(m_d[d]));
            chk(d == 0 ? "rr_out_ch" : "fx_out_ch", 64'(d == 0 ? rr_out_ch : fx_out_ch), 64'(m_ch[d]));
            if (load) begin
                if (w >= 0) begin
                    m_v[d]  = 1'b1;
                    m_d[d]  = dat[w];
                    m_ch[d] = w;
                    if (d == 0) m_ptr[d] = (w + 1) % int'(N);
                end else begin
                    m_v[d] = 1'b0;
                end
            end
        end
    endtask

    // Asynchronous reset asserted between edges with all requests high.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        in_valid = '1;
        rst_n    = 1'b0;
        #1;
        chk({tag, "_rr_valid"}, 64'(rr_out_valid), 64'd0);
        chk({tag, "_rr_data"},  64'(rr_out_data),  64'd0);
        chk({tag, "_rr_ch"},    64'(rr_out_ch),    64'd0);
        chk({tag, "_rr_ready"}, 64'(rr_in_ready),  64'd0);
        chk({tag, "_fx_valid"}, 64'(fx_out_valid), 64'd0);
        chk({tag, "_fx_ready"}, 64'(fx_in_ready),  64'd0);
        model_reset();
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int c = 0; c < int'(N); c++) dat[c] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pulse_reset("reset");

        // Single request on channel 2.
        for (int c = 0; c < int'(N); c++) dat[c] = {4'(c), 28'(c)};
        dat[2] = 32'hDEADBEEF;
        cycle(4'b0100, 1'b1, 1'b0);
        chk("single_in_ready", 64'(rr_in_ready), 64'h4);
        cycle(4'b0000, 1'b1, 1'b0);
        chk("single_valid", 64'(rr_out_valid), 64'd1);
        chk("single_data",  64'(rr_out_data),  64'hDEADBEEF);
        chk("single_ch",    64'(rr_out_ch),    64'd2);

        // Round-robin sweep with all channels requesting, then reset mid-stream.
        pulse_reset("rr_pre");
        for (int k = 0; k < 7; k++) begin
            cycle(4'b1111, 1'b1, 1'b1);
            if (k > 0) chk("rr_seq_ch", 64'(rr_out_ch), 64'((k - 1) % 4));
            if (k > 0) chk("rr_seq_valid", 64'(rr_out_valid), 64'd1);
        end
        pulse_reset("midstream");
        cycle(4'b1000, 1'b1, 1'b1);
        cycle(4'b1111, 1'b1, 1'b1);
        chk("post_reset_ch3", 64'(rr_out_ch), 64'd3);
        cycle(4'b1111, 1'b1, 1'b1);
        chk("post_reset_wrap", 64'(rr_out_ch), 64'd0);

        // Backpressure on a channel-1 beat.
        pulse_reset("bp_pre");
        cycle(4'b0010, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 1'b0, 1'b1);
            chk("bp_hold_ch", 64'(rr_out_ch), 64'd1);
            chk("bp_in_ready", 64'(rr_in_ready), 64'd0);
        end
        cycle(4'b1111, 1'b1, 1'b1);
        chk("bp_release_ready", 64'(rr_in_ready), 64'h4);
        cycle(4'b0000, 1'b1, 1'b1);
        chk("bp_next_ch", 64'(rr_out_ch), 64'd2);

        // Fixed priority starves channel 3 while channel 1 requests.
        for (int k = 0; k < 6; k++) begin
            cycle(4'b1010, 1'b1, 1'b1);
            if (k > 0) begin
                chk("fx_ch1", 64'(fx_out_ch), 64'd1);
                chk("fx_tag", 64'(fx_out_data[31:28]), 64'(fx_out_ch));
            end
        end

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
        end
        for (int k = 0; k < 40; k++) begin
            cycle(N'($urandom), 1'b1, 1'b1);
            if (fx_out_valid) chk("fx_rand_tag", 64'(fx_out_data[31:28]), 64'(fx_out_ch));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
